vtree_feeder: RTL
=================

Name: vtree_feeder

Overview:
- Producer-side front end for the virtual merge sorter tree.
- Accepts a record-at-a-time stream tagged with a way index, packs records into P-record batches per way, and buffers the batches per way.
- Issues a batch on the tree's din/dinen/din_idx port only when the tree reports that way's buffer empty (emp[i]).
- Replaces the testbench-style round-robin filler with a synthesizable, flow-controlled feeder.

Parameters:
- W_LOG, 3, log2 of number of ways (tree leaves).
- P_LOG, 3, log2 of records per batch (tree input width).
- FIFO_SIZE, 2, batch FIFO depth per way (power of two, >=2).
- DATW, 64, record width.
- KEYW, 32, key width (low KEYW bits of a record).
- EMP_LAT, 2, holdoff cycles after an issue before the same way may be issued again.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- in_data  in  DATW  input record.
- in_en  in  1  input record valid.
- in_idx  in  W_LOG  destination way of in_data.
- in_last  in  1  final record of the way's stream; qualified by in_en.
- in_rdy  out  1<<W_LOG  per-way ready.
- tree_emp  in  1<<W_LOG  tree per-way empty flags.
- dot  out  DATW<<P_LOG  batch to tree; record j occupies bits [DATW*(j+1)-1:DATW*j].
- doten  out  1  batch valid (tree dinen).
- dot_idx  out  W_LOG  way of batch (tree din_idx).
- all_done  out  1  every way has seen in_last and drained.
- err  out  1  sticky: a write occurred with in_rdy[in_idx]=0.

Behaviour:
- Reset (sync, RST=1): dot=0, doten=0, dot_idx=0, all_done=0, err=0.
  - All assembly counters, FIFOs, holdoff counters, done flags and the RR pointer are cleared.
  - in_rdy=0 while RST=1.
  - Reset mid-stream discards all buffered data.
- in_rdy[i] = ~RST & ~closed[i] & (fifo_cnt[i] < FIFO_SIZE).
  - This is based on registered count only; a same-cycle pop does not raise it.
- Write, when in_en & in_rdy[in_idx]:
  - Record goes to slot cnt[in_idx] of way in_idx's assembly register; cnt increments modulo P.
- Batch push, when cnt reaches P-1 or in_last is set:
  - The assembled batch (including the current record) is pushed into the way FIFO in that same cycle.
  - On in_last, the unfilled slots are padded with {DATW{1'b1}} (max-key sentinel).
  - cnt resets to 0 and closed[i] is set.
- in_en with in_rdy[in_idx]=0: record dropped, err<=1 and held until reset.
- Eligibility: elig[i] = fifo nonempty & tree_emp[i] & (hold[i]==0).
  - A pushed batch becomes eligible the cycle after the push.
- Arbitration: round-robin from pointer rr.
  - Grant g is the first eligible way at or after rr, modulo 2^W_LOG.
  - On grant, next cycle: dot=FIFO head of g, doten=1, dot_idx=g, FIFO g pops, hold[g]=EMP_LAT, rr=g+1 (wraps).
  - Latency from grant to doten is 1 cycle; at most one batch per cycle.
  - No eligible way: doten=0; dot and dot_idx hold their previous values.
- hold[i] decrements by 1 each cycle while nonzero.
  - A way is never reissued while its tree_emp may still reflect the pre-issue state.
- Simultaneous push and pop on the same way in one cycle: both take effect; fifo_cnt unchanged.
- Empty-stream way (in_last on the first record): one batch = record + P-1 sentinels.
- all_done<=1 when every way is closed, every FIFO is empty, and cnt is 0 everywhere. Stays 1 until reset.

Optional Feature:
- Macro VTREE_FEEDER_STAT_EN.
- Defined: adds outputs stat_issued (32 bits, count of doten cycles) and stat_stall (32 bits, cycles where some way has a nonempty FIFO and doten=0).
  - Both clear on reset and saturate at all-ones.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Fill: after reset, write 8 records each to ways 0..7 (W_LOG=3, P_LOG=3), tree_emp=all 1s.
  - Expect 8 batches, dot_idx 0,1,...,7 in order, one per cycle.
  - Way i batch record j key = i+1+8j.
- Holdoff: tree_emp[3] stuck at 1, way 3 given 3 batches.
  - Expect issues to way 3 spaced at least EMP_LAT+1 cycles apart.
- Backpressure: tree_emp=0, write 2 batches to way 5.
  - Expect in_rdy[5]=0.
  - A 17th write sets err=1 and the record is not issued.
  - Raise tree_emp[5]: the 2 batches come out intact.
- Padding: way 2 gets 3 records with in_last on the third.
  - Expect one batch with keys as written and slots 3..7 = all-ones.
  - in_rdy[2] then stays 0.
- Completion: in_last delivered on all 8 ways and all batches drained.
  - Expect all_done=1 exactly one cycle after the last pop.
- Reset mid-run: assert RST with batches buffered.
  - Expect doten=0 and in_rdy=0 during RST.
  - After release, no stale batch is issued, err=0, and rr restarts at way 0.

Source files
------------

// File: rtl/vtree_feeder.sv
// Producer-side front end for the virtual merge sorter tree: packs per-way records
// into P-record batches, buffers them per way and issues them when the tree way is empty.
// Optional VTREE_FEEDER_STAT_EN adds issue/stall counters.
module vtree_feeder #(
  parameter int W_LOG     = 3,
  parameter int P_LOG     = 3,
  parameter int FIFO_SIZE = 2,
  parameter int DATW      = 64,
  parameter int KEYW      = 32,
  parameter int EMP_LAT   = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [DATW-1:0]            in_data,
  input  logic                       in_en,
  input  logic [W_LOG-1:0]           in_idx,
  input  logic                       in_last,
  output logic [(1<<W_LOG)-1:0]      in_rdy,
  input  logic [(1<<W_LOG)-1:0]      tree_emp,
  output logic [(DATW<<P_LOG)-1:0]   dot,
  output logic                       doten,
  output logic [W_LOG-1:0]           dot_idx,
  output logic                       all_done,
  output logic                       err
`ifdef VTREE_FEEDER_STAT_EN
  , output logic [31:0]              stat_issued,
  output logic [31:0]                stat_stall
`endif
);
  localparam int NW = 1 << W_LOG;
  localparam int P  = 1 << P_LOG;
  localparam int BW = DATW * P;
  localparam int AW = $clog2(FIFO_SIZE);
  localparam int CW = AW + 1;
  localparam int EW = $clog2(EMP_LAT + 2);
  localparam logic [KEYW-1:0] MAX_KEY = '1;
  localparam logic [DATW-1:0] SENT = {{(DATW-KEYW){1'b1}}, MAX_KEY};

  logic [NW-1:0][P-1:0][DATW-1:0]      asm_q;
  logic [NW-1:0][P_LOG-1:0]            cnt_q;
  logic [NW-1:0]                       closed_q;
  logic [NW-1:0][FIFO_SIZE-1:0][BW-1:0] mem_q;
  logic [NW-1:0][AW-1:0]               wp_q, rp_q;
  logic [NW-1:0][CW-1:0]               fcnt_q;
  logic [NW-1:0][EW-1:0]               hold_q;
  logic [W_LOG-1:0]                    rr_q;

  logic                 wr, push, gnt_vld, done_c, any_ne;
  logic [W_LOG-1:0]     gnt;
  logic [NW-1:0]        elig;
  logic [P-1:0][DATW-1:0] wbat;

  always_comb begin
    for (int i = 0; i < NW; i++) begin
      in_rdy[i] = ~RST & ~closed_q[i] & (fcnt_q[i] < CW'(FIFO_SIZE));
      elig[i]   = (fcnt_q[i] != '0) & tree_emp[i] & (hold_q[i] == '0);
    end
  end

  assign wr   = in_en & in_rdy[in_idx];
  assign push = wr & ((cnt_q[in_idx] == P_LOG'(P-1)) | in_last);

  // Outgoing batch: earlier slots from the assembly register, current record,
  // then max-key sentinels (only reachable when in_last closes a short batch).
  always_comb begin
    for (int j = 0; j < P; j++) begin
      if (P_LOG'(j) == cnt_q[in_idx])     wbat[j] = in_data;
      else if (P_LOG'(j) < cnt_q[in_idx]) wbat[j] = asm_q[in_idx][j];
      else                                wbat[j] = SENT;
    end
  end

  always_comb begin
    logic [W_LOG-1:0] c;
    c       = '0;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = 0; k < NW; k++) begin
      c = rr_q + W_LOG'(k);
      if (!gnt_vld && elig[c]) begin
        gnt_vld = 1'b1;
        gnt     = c;
      end
    end
  end

  always_comb begin
    done_c = &closed_q;
    any_ne = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (fcnt_q[i] != '0) begin done_c = 1'b0; any_ne = 1'b1; end
      if (cnt_q[i] != '0)  done_c = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      closed_q <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      fcnt_q   <= '0;
      hold_q   <= '0;
      rr_q     <= '0;
      dot      <= '0;
      doten    <= 1'b0;
      dot_idx  <= '0;
      all_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        logic pu, po;
        pu = push & (in_idx == W_LOG'(i));
        po = gnt_vld & (gnt == W_LOG'(i));
        if (wr && in_idx == W_LOG'(i)) begin
          if (pu) begin
            cnt_q[i] <= '0;
            if (in_last) closed_q[i] <= 1'b1;
          end else begin
            asm_q[i][cnt_q[i]] <= in_data;
            cnt_q[i]           <= cnt_q[i] + P_LOG'(1);
          end
        end
        if (pu) begin
          mem_q[i][wp_q[i]] <= wbat;
          wp_q[i]           <= wp_q[i] + AW'(1);
        end
        if (po) rp_q[i] <= rp_q[i] + AW'(1);
        if (pu && !po)      fcnt_q[i] <= fcnt_q[i] + CW'(1);
        else if (po && !pu) fcnt_q[i] <= fcnt_q[i] - CW'(1);
        // Holdoff covers the tree's empty-flag latency after an issue.
        if (po)                     hold_q[i] <= EW'(EMP_LAT);
        else if (hold_q[i] != '0)   hold_q[i] <= hold_q[i] - EW'(1);
      end
      if (gnt_vld) begin
        dot     <= mem_q[gnt][rp_q[gnt]];
        doten   <= 1'b1;
        dot_idx <= gnt;
        rr_q    <= gnt + W_LOG'(1);
      end else begin
        doten   <= 1'b0;
      end
      if (done_c) all_done <= 1'b1;
      if (in_en && !in_rdy[in_idx]) err <= 1'b1;
    end
  end

`ifdef VTREE_FEEDER_STAT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (doten && !(&stat_issued))          stat_issued <= stat_issued + 32'd1;
      if (!doten && any_ne && !(&stat_stall)) stat_stall <= stat_stall + 32'd1;
    end
  end
`else
  logic unused_any_ne;
  assign unused_any_ne = any_ne;
`endif
endmodule
